// File: rtl/apb_master_arbiter.sv
// Two-requester APB master: round-robin arbitration between req0/req1, APB SETUP/ACCESS
// sequencing, address-window and alignment checks, and a Pready timeout.
module apb_master_arbiter #(
  parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
  parameter int unsigned WIN_BYTES = 16,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        Pclk,
  input  logic        Prst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_addr,
  input  logic        req0_write,
  input  logic [31:0] req0_wdata,
  output logic        rsp0_valid,
  output logic [31:0] rsp0_rdata,
  output logic        rsp0_err,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_addr,
  input  logic        req1_write,
  input  logic [31:0] req1_wdata,
  output logic        rsp1_valid,
  output logic [31:0] rsp1_rdata,
  output logic        rsp1_err,
  output logic [31:0] Paddr,
  output logic        Pwrite,
  output logic        Psel,
  output logic        Penable,
  output logic [31:0] Pwdata,
  input  logic [31:0] Prdata,
  input  logic        Pready,
  input  logic        Pslverr
);

  localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_ERR} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               prio_q, prio_d;
  logic               owner_q, owner_d;
  logic [31:0]        paddr_q, paddr_d;
  logic [31:0]        pwdata_q, pwdata_d;
  logic               pwrite_q, pwrite_d;
  logic               psel_q, psel_d;
  logic               penable_q, penable_d;
  logic [1:0]         rsp_valid_q, rsp_valid_d;
  logic [1:0]         rsp_err_q, rsp_err_d;
  logic [31:0]        rsp_rdata_q [2];
  logic [31:0]        rsp_rdata_d [2];

  logic [1:0]         valid_vec;
  logic [1:0]         write_vec;
  logic [1:0]         ready_vec;
  logic [31:0]        addr_vec  [2];
  logic [31:0]        wdata_vec [2];

  logic               grant_idx;
  logic               addr_ok;
  logic [31:0]        sel_addr;
  logic [31:0]        offset;
  logic               accept;
  logic               done;
  logic               done_err;
  logic [31:0]        done_rdata;

  assign valid_vec    = {req1_valid, req0_valid};
  assign write_vec    = {req1_write, req0_write};
  assign addr_vec[0]  = req0_addr;
  assign addr_vec[1]  = req1_addr;
  assign wdata_vec[0] = req0_wdata;
  assign wdata_vec[1] = req1_wdata;

  // prio_q names the requester that wins a tie; it flips away from whoever was just granted.
  always_comb begin
    grant_idx = (&valid_vec) ? prio_q : valid_vec[1];
    sel_addr  = addr_vec[grant_idx];
    offset    = sel_addr - BASE_ADDR;
    addr_ok   = (sel_addr >= BASE_ADDR) && (offset < WIN_BYTES) && (sel_addr[1:0] == 2'b00);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    prio_d     = prio_q;
    owner_d    = owner_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;
    psel_d     = 1'b0;
    penable_d  = 1'b0;
    accept     = 1'b0;
    done       = 1'b0;
    done_err   = 1'b0;
    done_rdata = '0;
    case (state_q)
      S_IDLE: begin
        if (|valid_vec) begin
          accept  = 1'b1;
          owner_d = grant_idx;
          prio_d  = ~grant_idx;
          if (addr_ok) begin
            state_d  = S_SETUP;
            psel_d   = 1'b1;
            paddr_d  = sel_addr;
            pwrite_d = write_vec[grant_idx];
            pwdata_d = wdata_vec[grant_idx];
          end else begin
            state_d = S_ERR;
          end
        end
      end
      S_SETUP: begin
        state_d   = S_ACCESS;
        psel_d    = 1'b1;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      S_ACCESS: begin
        if (Pready) begin
          done       = 1'b1;
          done_err   = Pslverr;
          done_rdata = (!pwrite_q && !Pslverr) ? Prdata : 32'h0;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Hung slave: abandon the transfer rather than stall the owner forever.
          done     = 1'b1;
          done_err = 1'b1;
          state_d  = S_IDLE;
        end else begin
          cnt_d     = cnt_q + 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b1;
        end
      end
      S_ERR: begin
        done     = 1'b1;
        done_err = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_req
      assign ready_vec[gi]   = accept && (grant_idx == 1'(gi));
      assign rsp_valid_d[gi] = done && (owner_q == 1'(gi));
      assign rsp_err_d[gi]   = done && (owner_q == 1'(gi)) && done_err;
      assign rsp_rdata_d[gi] = (done && (owner_q == 1'(gi))) ? done_rdata : 32'h0;
    end
  endgenerate

  always_ff @(posedge Pclk or posedge Prst) begin
    if (Prst) begin
      state_q        <= S_IDLE;
      cnt_q          <= '0;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      paddr_q        <= '0;
      pwdata_q       <= '0;
      pwrite_q       <= 1'b0;
      psel_q         <= 1'b0;
      penable_q      <= 1'b0;
      rsp_valid_q    <= '0;
      rsp_err_q      <= '0;
      rsp_rdata_q[0] <= '0;
      rsp_rdata_q[1] <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      prio_q         <= prio_d;
      owner_q        <= owner_d;
      paddr_q        <= paddr_d;
      pwdata_q       <= pwdata_d;
      pwrite_q       <= pwrite_d;
      psel_q         <= psel_d;
      penable_q      <= penable_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_err_q      <= rsp_err_d;
      rsp_rdata_q[0] <= rsp_rdata_d[0];
      rsp_rdata_q[1] <= rsp_rdata_d[1];
    end
  end

  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign rsp0_valid = rsp_valid_q[0];
  assign rsp1_valid = rsp_valid_q[1];
  assign rsp0_err   = rsp_err_q[0];
  assign rsp1_err   = rsp_err_q[1];
  assign rsp0_rdata = rsp_rdata_q[0];
  assign rsp1_rdata = rsp_rdata_q[1];
  assign Paddr      = paddr_q;
  assign Pwdata     = pwdata_q;
  assign Pwrite     = pwrite_q;
  assign Psel       = psel_q;
  assign Penable    = penable_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed and random transfers, each checked against
// latency/error/data expectations derived from the protocol rules.
module tb_apb_master_arbiter;

  localparam logic [31:0] BASE = 32'h2000_0000;
  localparam int WIN = 16;
  localparam int TMO = 16;

  logic        Pclk = 1'b0;
  logic        Prst;
  logic        req0_valid, req0_ready, req0_write, rsp0_valid, rsp0_err;
  logic [31:0] req0_addr, req0_wdata, rsp0_rdata;
  logic        req1_valid, req1_ready, req1_write, rsp1_valid, rsp1_err;
  logic [31:0] req1_addr, req1_wdata, rsp1_rdata;
  logic [31:0] Paddr, Pwdata, Prdata;
  logic        Pwrite, Psel, Penable, Pready, Pslverr;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  int last_grant = 1;  // model: requester granted most recently (1 => req0 wins first tie)

  apb_master_arbiter dut (
    .Pclk(Pclk), .Prst(Prst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
    .req0_write(req0_write), .req0_wdata(req0_wdata), .rsp0_valid(rsp0_valid),
    .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
    .req1_write(req1_write), .req1_wdata(req1_wdata), .rsp1_valid(rsp1_valid),
    .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
    .Paddr(Paddr), .Pwrite(Pwrite), .Psel(Psel), .Penable(Penable), .Pwdata(Pwdata),
    .Prdata(Prdata), .Pready(Pready), .Pslverr(Pslverr)
  );

  always #5 Pclk = ~Pclk;
  always @(posedge Pclk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic get_ready(input int n);
    return (n != 0) ? req1_ready : req0_ready;
  endfunction
  function automatic logic get_rsp_valid(input int n);
    return (n != 0) ? rsp1_valid : rsp0_valid;
  endfunction
  function automatic logic get_rsp_err(input int n);
    return (n != 0) ? rsp1_err : rsp0_err;
  endfunction
  function automatic logic [31:0] get_rsp_rdata(input int n);
    return (n != 0) ? rsp1_rdata : rsp0_rdata;
  endfunction

  function automatic bit addr_ok(input logic [31:0] a);
    return (a >= BASE) && ((a - BASE) < WIN) && (a[1:0] == 2'b00);
  endfunction

  task automatic set_req(input int n, input logic v, input logic [31:0] a, input logic w,
                         input logic [31:0] d);
    if (n == 0) begin
      req0_valid = v; req0_addr = a; req0_write = w; req0_wdata = d;
    end else begin
      req1_valid = v; req1_addr = a; req1_write = w; req1_wdata = d;
    end
  endtask

  // Called just after a falling edge with the DUT idle; returns just after a falling edge.
  task automatic run_txn(input int n, input logic [31:0] a, input logic wr,
                         input logic [31:0] wd, input int waits, input logic [31:0] sd,
                         input logic serr, input string tag);
    bit          ok = addr_ok(a);
    bit          tmo;
    int          acc_cyc = -1;
    int          rsp_cyc = -1;
    int          psel_cycles = 0;
    int          access_cnt = 0;
    int          bad_apb = 0;
    int          stray = 0;
    int          exp_lat, exp_psel;
    logic        exp_err, got_err;
    logic [31:0] exp_rd, got_rd;
    logic [31:0] paddr_before = Paddr;

    got_err = 1'b0;
    got_rd  = '0;
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    set_req(n, 1'b1, a, wr, wd);
    for (int k = 0; k < 20 && acc_cyc < 0; k++) begin
      #1;
      if (get_ready(n)) acc_cyc = cyc;
      @(negedge Pclk);
    end
    set_req(n, 1'b0, a, wr, wd);
    check({tag, " accepted"}, 32'(acc_cyc >= 0), 32'd1);
    if (acc_cyc < 0) return;
    last_grant = n;

    for (int k = 0; k < 40 && rsp_cyc < 0; k++) begin
      Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
      if (Psel) begin
        psel_cycles++;
        if (Paddr !== a || Pwrite !== wr || (wr && Pwdata !== wd)) bad_apb++;
      end
      if (!ok && Paddr !== paddr_before) bad_apb++;
      if (Psel && Penable) begin
        access_cnt++;
        if (access_cnt == waits + 1) begin
          Pready = 1'b1; Pslverr = serr; Prdata = sd;
        end
      end
      if (get_rsp_valid(1 - n)) stray++;
      if (get_rsp_valid(n)) begin
        rsp_cyc = cyc;
        got_err = get_rsp_err(n);
        got_rd  = get_rsp_rdata(n);
      end else begin
        @(negedge Pclk);
      end
    end
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;

    tmo      = ok && (waits >= TMO);
    exp_lat  = !ok ? 2 : (tmo ? TMO + 2 : waits + 3);
    exp_psel = !ok ? 0 : 1 + (tmo ? TMO : waits + 1);
    exp_err  = !ok || tmo || serr;
    exp_rd   = (exp_err || wr) ? 32'h0 : sd;

    check({tag, " rsp seen"}, 32'(rsp_cyc >= 0), 32'd1);
    check({tag, " latency"}, 32'(rsp_cyc - acc_cyc), 32'(exp_lat));
    check({tag, " err"}, 32'(got_err), 32'(exp_err));
    check({tag, " rdata"}, got_rd, exp_rd);
    check({tag, " psel cycles"}, 32'(psel_cycles), 32'(exp_psel));
    check({tag, " apb outputs"}, 32'(bad_apb), 32'd0);
    check({tag, " other rsp"}, 32'(stray), 32'd0);
    @(negedge Pclk);
    check({tag, " single pulse"}, 32'(get_rsp_valid(n)), 32'd0);
    $display("txn %s: req%0d addr=%h wr=%0d waits=%0d lat=%0d err=%0d rdata=%h",
             tag, n, a, wr, waits, rsp_cyc - acc_cyc, got_err, got_rd);
  endtask

  // Both requesters keep valid high until each has had two zero-wait transfers.
  task automatic run_arb();
    int g0 = 0, g1 = 0, rsp_n0 = 0, rsp_n1 = 0, bad = 0, last_acc = -1, owner = 0;
    int winner, exp_w;
    Pready = 1'b1; Pslverr = 1'b0; Prdata = '0;
    for (int k = 0; k < 60 && (rsp_n0 + rsp_n1) < 4; k++) begin
      set_req(0, g0 < 2, BASE, 1'b1, 32'h0000_0011);
      set_req(1, g1 < 2, BASE + 32'd4, 1'b1, 32'h0000_0022);
      #1;
      if (Psel && Paddr !== ((owner != 0) ? BASE + 32'd4 : BASE)) bad++;
      if (Psel && (req0_ready || req1_ready)) bad++;
      if (rsp0_valid) begin rsp_n0++; if (rsp0_err) bad++; end
      if (rsp1_valid) begin rsp_n1++; if (rsp1_err) bad++; end
      if (req0_ready && req1_ready) bad++;
      else if (req0_ready || req1_ready) begin
        winner = req1_ready ? 1 : 0;
        exp_w  = (req0_valid && req1_valid) ? 1 - last_grant : (req1_valid ? 1 : 0);
        check("arb winner", 32'(winner), 32'(exp_w));
        if (last_acc >= 0) check("arb spacing", 32'(cyc - last_acc), 32'd3);
        last_acc   = cyc;
        last_grant = winner;
        owner      = winner;
        if (winner != 0) g1++; else g0++;
        $display("arb grant: req%0d at cycle %0d", winner, cyc);
      end
      @(negedge Pclk);
    end
    set_req(0, 1'b0, BASE, 1'b0, 32'h0);
    set_req(1, 1'b0, BASE, 1'b0, 32'h0);
    Pready = 1'b0;
    check("arb rsp0 count", 32'(rsp_n0), 32'd2);
    check("arb rsp1 count", 32'(rsp_n1), 32'd2);
    check("arb protocol", 32'(bad), 32'd0);
  endtask

  task automatic run_reset_mid_access();
    int acc = 0, stray = 0;
    Pready = 1'b0; Pslverr = 1'b0;
    set_req(0, 1'b1, BASE + 32'd8, 1'b0, 32'h0);
    for (int k = 0; k < 20 && acc == 0; k++) begin
      #1;
      if (req0_ready) acc = 1;
      @(negedge Pclk);
    end
    set_req(0, 1'b0, BASE, 1'b0, 32'h0);
    check("rst accepted", 32'(acc), 32'd1);
    @(negedge Pclk);
    check("rst in access", {30'h0, Psel, Penable}, 32'h3);
    #2 Prst = 1'b1;
    #1;
    check("rst async drop", {30'h0, Psel, Penable}, 32'h0);
    @(negedge Pclk);
    @(negedge Pclk);
    Prst = 1'b0;
    last_grant = 1;
    for (int k = 0; k < 24; k++) begin
      if (rsp0_valid || rsp1_valid || Psel) stray++;
      @(negedge Pclk);
    end
    check("rst no rsp", 32'(stray), 32'd0);
    $display("txn reset-mid-access: request dropped, stray=%0d", stray);
  endtask

  initial begin
    int          n, sel, waits;
    logic [31:0] a;
    Prst = 1'b1;
    set_req(0, 1'b0, 32'h0, 1'b0, 32'h0);
    set_req(1, 1'b0, 32'h0, 1'b0, 32'h0);
    Pready = 1'b0; Pslverr = 1'b0; Prdata = '0;
    repeat (3) @(negedge Pclk);
    check("reset psel/penable", {30'h0, Psel, Penable}, 32'h0);
    check("reset paddr", Paddr, 32'h0);
    check("reset pwdata", Pwdata, 32'h0);
    check("reset ready/rsp", {26'h0, Pwrite, req0_ready, req1_ready, rsp0_valid, rsp1_valid,
                              rsp0_err | rsp1_err}, 32'h0);
    check("reset rdata", rsp0_rdata | rsp1_rdata, 32'h0);
    Prst = 1'b0;
    @(negedge Pclk);

    run_txn(0, BASE, 1'b1, 32'h0000_00A5, 0, 32'h0, 1'b0, "wr0");
    run_txn(1, BASE + 32'd4, 1'b0, 32'h0, 2, 32'h1234_5678, 1'b0, "rd1_wait2");
    run_arb();
    run_txn(0, BASE + 32'd16, 1'b0, 32'h0, 0, 32'hDEAD_BEEF, 1'b0, "oow");
    run_txn(1, BASE + 32'd2, 1'b1, 32'h5, 0, 32'h0, 1'b0, "misaligned");
    run_txn(1, BASE + 32'd8, 1'b0, 32'h0, 30, 32'hBEEF_0000, 1'b0, "timeout");
    run_txn(0, BASE + 32'd4, 1'b0, 32'h0, 15, 32'hCAFE_F00D, 1'b0, "wait15");
    run_txn(0, BASE + 32'd12, 1'b0, 32'h0, 1, 32'h0BAD_0BAD, 1'b1, "slverr");
    run_reset_mid_access();
    run_txn(1, BASE + 32'd12, 1'b1, 32'h0000_5A5A, 0, 32'h0, 1'b0, "post_rst");

    for (int i = 0; i < 16; i++) begin
      n   = int'($urandom_range(0, 1));
      sel = int'($urandom_range(0, 9));
      if (sel == 0)      a = BASE + 32'd16 + 32'($urandom_range(0, 3)) * 32'd4;
      else if (sel == 1) a = BASE + 32'($urandom_range(0, 3)) * 32'd4 + 32'($urandom_range(1, 3));
      else if (sel == 2) a = BASE - 32'd4;
      else               a = BASE + 32'($urandom_range(0, 3)) * 32'd4;
      waits = ($urandom_range(0, 9) == 0) ? 16 + int'($urandom_range(0, 4))
                                          : int'($urandom_range(0, 4));
      run_txn(n, a, 1'($urandom_range(0, 1)), $urandom, waits, $urandom,
              1'($urandom_range(0, 7) == 0), $sformatf("rand%0d", i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
